// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter: FSM states,
// flash word width/error word, and small index helpers.
package flash_arb_pkg;

  localparam int FLASH_DATA_W = 16;
  localparam logic [FLASH_DATA_W-1:0] FLASH_ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for 0 <= a, b < n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/flash_read_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first active request at or after
// ptr (wrapping) wins; returns a one-hot grant and its index.
module rr_picker
  import flash_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    // Scan from lowest to highest priority so the nearest requester overwrites last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == wrap_add(int'(ptr), k, NUM_REQ) && req[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flash read port among NUM_REQ requesters,
// with a one-entry last-word buffer and a watchdog on hung reads.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [FLASH_DATA_W-1:0]   resp_data,
  output logic                      resp_err,
  output logic                      mem_read_req,
  output logic [ADDR_W-1:0]         mem_read_addr,
  input  logic                      mem_read_ready,
  input  logic [FLASH_DATA_W-1:0]   mem_read_data
);

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT) + 1;

  arb_state_t state, next_state;

  logic [IDX_W-1:0]        rr_ptr, win_idx, pick_idx;
  logic [NUM_REQ-1:0]      elig, pick_grant;
  logic [ADDR_W-1:0]       pick_addr, buf_addr;
  logic [FLASH_DATA_W-1:0] buf_data, rsp_word;
  logic                    buf_valid, rsp_err, hit, timed_out;
  logic [TIMER_W-1:0]      timer;

  // The requester being answered this cycle may still show its old request.
  assign elig = req & ~resp_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign pick_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign hit       = buf_valid && (pick_addr == buf_addr);
  assign timed_out = (timer == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (|pick_grant) next_state = hit ? S_RESP : S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (mem_read_ready || timed_out) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      win_idx       <= '0;
      mem_read_addr <= '0;
      rsp_word      <= '0;
      rsp_err       <= 1'b0;
      timer         <= '0;
      buf_valid     <= 1'b0;
      mem_read_req  <= 1'b0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
    end else begin
      state        <= next_state;
      mem_read_req <= (state == S_ISSUE);
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|pick_grant) begin
            win_idx       <= pick_idx;
            mem_read_addr <= pick_addr;
            rsp_word      <= buf_data;
            rsp_err       <= 1'b0;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (timer != '1) timer <= timer + 1'b1;
          if (mem_read_ready) begin
            rsp_word  <= mem_read_data;
            rsp_err   <= 1'b0;
            buf_valid <= 1'b1;
          end else if (timed_out) begin
            rsp_word <= FLASH_ERR_DATA;
            rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          resp_valid <= NUM_REQ'(1) << win_idx;
          resp_data  <= rsp_word;
          resp_err   <= rsp_err;
          rr_ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        default: ;
      endcase
      // A flush racing a fill leaves the buffer invalid.
      if (flush) buf_valid <= 1'b0;
    end
  end

  // NOTE: buffer contents need no reset; buf_valid alone gates their use.
  always_ff @(posedge clk) begin
    if (state == S_WAIT && mem_read_ready) begin
      buf_addr <= mem_read_addr;
      buf_data <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: vector table of single transactions
// plus sequences for fairness, flush race, timeout and mid-read reset.
module tb_flash_read_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 21;
  localparam int TIMEOUT = 1024;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic                      flush;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [15:0]               resp_data;
  logic                      resp_err;
  logic                      mem_read_req;
  logic [ADDR_W-1:0]         mem_read_addr;
  logic                      mem_read_ready;
  logic [15:0]               mem_read_data;

  flash_read_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_addr       (req_addr),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .mem_read_req   (mem_read_req),
    .mem_read_addr  (mem_read_addr),
    .mem_read_ready (mem_read_ready),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents seen by the model.
  function automatic logic [15:0] flash_word(input logic [ADDR_W-1:0] a);
    if (a == 21'h10) return 16'h1234;
    return {a[14:0], 1'b1} ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " resp_valid"},    32'(resp_valid),    0);
    check({tag, " resp_data"},     32'(resp_data),     0);
    check({tag, " resp_err"},      32'(resp_err),      0);
    check({tag, " mem_read_req"},  32'(mem_read_req),  0);
    check({tag, " mem_read_addr"}, 32'(mem_read_addr), 0);
  endtask

  task automatic wait_resp(input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (resp_valid == '0 && lat < budget);
    check("resp_arrived", 32'(|resp_valid), 1);
  endtask

  // Flash controller model: answers model_latency cycles after seeing
  // mem_read_req (negative latency = never answers).
  int               model_latency = 12;
  int               countdown = -1;
  int               reads = 0;
  int               addr_unstable = 0;
  int               last_req_cyc = 0;
  logic             flush_on_ready = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  initial begin
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    flush          = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_read_ready = 1'b0;
      flush          = 1'b0;
      if (rst) begin
        countdown = -1;
      end else begin
        if (countdown >= 0 && mem_read_addr !== last_addr) addr_unstable++;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            mem_read_ready = 1'b1;
            mem_read_data  = flash_word(last_addr);
            flush          = flush_on_ready;
            countdown      = -1;
          end
        end
        if (mem_read_req) begin
          reads++;
          last_addr    = mem_read_addr;
          last_req_cyc = cyc;
          countdown    = (model_latency > 0) ? model_latency : -1;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]        req;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [1:0]        exp_valid;
    logic [15:0]       exp_data;
    int                exp_reads;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, r0, w, n, t_resp;
    logic [ADDR_W-1:0] fa[2];

    req      = '0;
    req_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    vecs[0] = '{2'b01, 21'h00010, 21'h00000, 2'b01, 16'h1234, 1};            // single miss
    vecs[1] = '{2'b01, 21'h00010, 21'h00000, 2'b01, 16'h1234, 0};            // hit
    vecs[2] = '{2'b10, 21'h00000, 21'h00010, 2'b10, 16'h1234, 0};            // hit, other requester
    vecs[3] = '{2'b10, 21'h00000, 21'h00033, 2'b10, flash_word(21'h33), 1};
    vecs[4] = '{2'b11, 21'h00044, 21'h00033, 2'b01, flash_word(21'h44), 1};  // ptr=0
    vecs[5] = '{2'b11, 21'h00044, 21'h00033, 2'b10, flash_word(21'h33), 1};  // ptr=1
    vecs[6] = '{2'b11, 21'h00033, 21'h00055, 2'b01, flash_word(21'h33), 0};  // ptr=0, hit
    vecs[7] = '{2'b10, 21'h00000, 21'h1FFFFF, 2'b10, flash_word(21'h1FFFFF), 1};

    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      set_addr(0, vecs[v].a0);
      set_addr(1, vecs[v].a1);
      req = vecs[v].req;
      r0  = reads;
      wait_resp(200, lat);
      check($sformatf("v%0d resp_valid", v), 32'(resp_valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d resp_data", v),  32'(resp_data),  32'(vecs[v].exp_data));
      check($sformatf("v%0d resp_err", v),   32'(resp_err),   0);
      check($sformatf("v%0d flash reads", v), 32'(reads - r0), 32'(vecs[v].exp_reads));
      check($sformatf("v%0d latency", v), 32'(lat), (vecs[v].exp_reads != 0) ? 32'd16 : 32'd2);
      if (vecs[v].exp_reads != 0)
        check($sformatf("v%0d mem_read_addr", v), 32'(last_addr),
              32'(vecs[v].exp_valid[0] ? vecs[v].a0 : vecs[v].a1));
      req = '0;
    end

    // Fairness: both requests held; grants must alternate starting at 0.
    @(posedge clk); #1;
    fa[0] = 21'h100;
    fa[1] = 21'h200;
    set_addr(0, fa[0]);
    set_addr(1, fa[1]);
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_resp(200, lat);
      w = resp_valid[1] ? 1 : 0;
      check($sformatf("fair grant %0d", g), 32'(resp_valid), (g % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("fair data %0d", g), 32'(resp_data), 32'(flash_word(fa[w])));
      fa[w] = fa[w] + 1'b1;
      set_addr(w, fa[w]);
    end
    req = '0;

    // Flush in the same cycle as mem_read_ready: response still delivered, buffer invalid.
    @(posedge clk); #1;
    flush_on_ready = 1'b1;
    set_addr(0, 21'h20);
    req = 2'b01;
    r0  = reads;
    wait_resp(200, lat);
    check("flush race resp_valid", 32'(resp_valid), 1);
    check("flush race resp_data",  32'(resp_data),  32'(flash_word(21'h20)));
    req = '0;
    flush_on_ready = 1'b0;
    @(posedge clk); #1;
    req = 2'b01;
    r0  = reads;
    wait_resp(200, lat);
    check("after flush reread", 32'(reads - r0), 1);
    check("after flush data",   32'(resp_data),  32'(flash_word(21'h20)));
    req = '0;

    // Timeout: controller never answers.
    @(posedge clk); #1;
    model_latency = -1;
    set_addr(0, 21'h77);
    req = 2'b01;
    r0  = reads;
    wait_resp(1200, lat);
    t_resp = cyc;
    check("timeout spacing",    32'(t_resp - last_req_cyc), 32'(TIMEOUT + 1));
    check("timeout resp_valid", 32'(resp_valid), 1);
    check("timeout resp_data",  32'(resp_data),  32'hFFFF);
    check("timeout resp_err",   32'(resp_err),   1);
    check("timeout reads",      32'(reads - r0), 1);
    req = '0;
    model_latency = 12;

    // Buffer must still hold 0x20 after the timed-out read.
    @(posedge clk); #1;
    set_addr(0, 21'h20);
    req = 2'b01;
    r0  = reads;
    wait_resp(200, lat);
    check("post-timeout hit latency", 32'(lat), 2);
    check("post-timeout hit reads",   32'(reads - r0), 0);
    check("post-timeout hit data",    32'(resp_data), 32'(flash_word(21'h20)));
    check("post-timeout hit err",     32'(resp_err), 0);
    req = '0;

    // Reset while waiting on the flash.
    @(posedge clk); #1;
    model_latency = 40;
    set_addr(0, 21'h99);
    req = 2'b01;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_read_req && n < 10);
    check("rst test read issued", 32'(mem_read_req), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_zero("rst async");
    req = '0;
    @(posedge clk); #1;
    check_zero("rst held");
    @(negedge clk);
    rst = 1'b0;

    // Controller power-up hold; rr_ptr and buf_valid must be back at reset values.
    model_latency = 520;
    @(posedge clk); #1;
    set_addr(0, 21'h20);
    set_addr(1, 21'hAA);
    req = 2'b11;
    r0  = reads;
    wait_resp(700, lat);
    check("post-rst resp_valid", 32'(resp_valid), 1);
    check("post-rst resp_data",  32'(resp_data),  32'(flash_word(21'h20)));
    check("post-rst resp_err",   32'(resp_err),   0);
    check("post-rst reads",      32'(reads - r0), 1);
    check("post-rst latency",    32'(lat),        32'd524);
    req = '0;

    @(posedge clk); #1;
    check("mem_read_addr stable in wait", 32'(addr_unstable), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
